load_sequencer: RTL and testbench
=================================

// Module: load_sequencer
// PURPOSE
//   Sequences data-memory reads for CPU loads (LB/LH/LW/LBU/LHU) and returns the extended result.
//   Aligned accesses take one word read. Accesses that cross a word boundary take two reads; their bytes are merged and then extended.
//   Sits between the MEM stage and the synchronous-read data memory. Gives the pipeline a valid/ready load port.
// PARAMETERS
//   W_SIZE  32  data word width in bits (only 32 supported)
//   ADDR_W  16  byte-address width
// PORTS
//   clk          in   1       clock, rising edge
//   rst_n        in   1       asynchronous, active-low reset
//   req_valid    in   1       load request valid
//   req_ready    out  1       sequencer can accept a request
//   req_addr     in   ADDR_W  byte address
//   req_func3    in   3       0=LB 1=LH 2=LW 4=LBU 5=LHU
//   rsp_valid    out  1       result valid; held until rsp_ready
//   rsp_ready    in   1       consumer accepts result
//   rsp_data     out  W_SIZE  sign/zero-extended load result
//   rsp_err      out  1       illegal func3 (3,6,7); qualified by rsp_valid
//   mem_en       out  1       memory read strobe
//   mem_addr     out  ADDR_W  word-aligned byte address, low 2 bits always 0
//   mem_rdata    in   W_SIZE  read data, valid the cycle after mem_en
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; rsp_valid=0, rsp_data=0, rsp_err=0.
//     mem_en=0, req_ready=0 (both gated by rst_n); internal regs cleared.
//   mem_addr is 0 whenever mem_en=0.
//   FSM states: IDLE, WAIT0, WAIT1, RESP.
//   IDLE:
//     req_ready=1. A request is accepted on req_valid at cycle T.
//     In T: mem_en=1 combinationally, mem_addr={req_addr[ADDR_W-1:2],2'b00}. Latch addr, func3, span.
//     Next state WAIT0.
//   span (second read needed): LH/LHU with addr[1:0]==3, or LW with addr[1:0]!=0.
//     LB/LBU and illegal func3 never span.
//   WAIT0: capture mem_rdata into lo.
//     If span: mem_en=1, mem_addr=(base+4) mod 2^ADDR_W (wraps 0xFFFC->0x0000); next state WAIT1.
//     Otherwise: register the result; next state RESP.
//   WAIT1: capture mem_rdata as hi; register the result; next state RESP.
//   Result: sh = {hi,lo} >> (8*addr[1:0]); hi=0 when no span.
//     LB  -> sext(sh[7:0])
//     LBU -> zext(sh[7:0])
//     LH  -> sext(sh[15:0])
//     LHU -> zext(sh[15:0])
//     LW  -> sh[31:0]
//     illegal -> lo unmodified, with rsp_err=1
//   RESP: rsp_valid=1; rsp_data and rsp_err stay stable.
//     On rsp_ready=1, go to IDLE; rsp_valid=0 from the next cycle.
//   Latency: accept at T -> rsp_valid at T+2 (aligned) or T+3 (spanning).
//     With rsp_ready held high, a new request is accepted no earlier than T+3 (aligned) or T+4 (spanning).
//   req_ready=0 in WAIT0, WAIT1 and RESP; req_valid there is ignored and must be held by the requester.
//   rsp_ready while not in RESP: ignored.
//   Reset asserted in any state aborts the access: no rsp_valid is produced, and any in-flight mem_rdata is discarded.
// TESTING
//   1. LW @0x0100, mem[0x0100]=0xDEADBEEF
//      -> one read; rsp_data=0xDEADBEEF, rsp_valid at T+2.
//   2. LH @0x0102, mem[0x0100]=0x80011234
//      -> rsp_data=0xFFFF8001. LHU at the same address -> 0x00008001.
//   3. LH @0x0103, mem[0x0100]=0xAABBCCDD, mem[0x0104]=0x11223344
//      -> reads 0x0100 then 0x0104; rsp_data=0x000044AA at T+3.
//      LW @0x0101 with the same memory -> 0x44AABBCC.
//   4. LW @0xFFFE, mem[0xFFFC]=0x55667788, mem[0x0000]=0x99AABBCC
//      -> second mem_addr=0x0000; rsp_data=0xBBCC5566.
//   5. rsp_ready low for 3 cycles in RESP
//      -> rsp_valid, rsp_data and rsp_err stable; req_ready=0 throughout; IDLE one cycle after rsp_ready=1.
//   6. rst_n pulsed low during WAIT1
//      -> mem_en=0 and rsp_valid=0 immediately; no response.
//      After release, req_ready=1 and a fresh LB @0x0001 of 0x0000F000 returns 0xFFFFFFF0.
//      func3=3 -> rsp_err=1.

Source files
------------

// File: rtl/load_sequencer.sv
// Load sequencer between MEM stage and synchronous data memory.
// Splits word-crossing loads into two reads, merges and extends.
module load_sequencer #(
  parameter int W_SIZE = 32,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_func3,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W_SIZE-1:0] rsp_data,
  output logic              rsp_err,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [W_SIZE-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT0,
    WAIT1,
    RESP
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        func3_q;
  logic              span_q;
  logic [W_SIZE-1:0] lo;
  logic [ADDR_W-3:0] nxt_word;

  function automatic logic needs_span(
    input logic [1:0] ofs,
    input logic [2:0] f3
  );
    unique case (f3)
      3'd1, 3'd5: return ofs == 2'd3;
      3'd2:       return ofs != 2'd0;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [2:0] f3);
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

  function automatic logic [W_SIZE-1:0] extend(
    input logic [W_SIZE-1:0] hi,
    input logic [W_SIZE-1:0] lo_w,
    input logic [1:0]        ofs,
    input logic [2:0]        f3
  );
    logic [W_SIZE-1:0] sh;
    sh = W_SIZE'({hi, lo_w} >> {ofs, 3'b000});
    unique case (f3)
      3'd0:    return {{(W_SIZE-8){sh[7]}}, sh[7:0]};
      3'd4:    return {{(W_SIZE-8){1'b0}}, sh[7:0]};
      3'd1:    return {{(W_SIZE-16){sh[15]}}, sh[15:0]};
      3'd5:    return {{(W_SIZE-16){1'b0}}, sh[15:0]};
      3'd2:    return sh;
      default: return lo_w;
    endcase
  endfunction

  assign nxt_word  = addr_q[ADDR_W-1:2] + (ADDR_W-2)'(1);
  assign req_ready = rst_n && (state == IDLE);

  // Read strobe is combinational so the first read issues in the accept cycle.
  always_comb begin
    mem_en   = 1'b0;
    mem_addr = '0;
    if (rst_n) begin
      unique case (state)
        IDLE: if (req_valid) begin
          mem_en   = 1'b1;
          mem_addr = {req_addr[ADDR_W-1:2], 2'b00};
        end
        WAIT0: if (span_q) begin
          mem_en   = 1'b1;
          mem_addr = {nxt_word, 2'b00};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      func3_q   <= '0;
      span_q    <= 1'b0;
      lo        <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          func3_q <= req_func3;
          span_q  <= needs_span(req_addr[1:0], req_func3);
          state   <= WAIT0;
        end
        WAIT0: begin
          lo <= mem_rdata;
          if (span_q) begin
            state <= WAIT1;
          end else begin
            rsp_data  <= extend('0, mem_rdata, addr_q[1:0], func3_q);
            rsp_err   <= is_illegal(func3_q);
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        WAIT1: begin
          rsp_data  <= extend(mem_rdata, lo, addr_q[1:0], func3_q);
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_sequencer.sv
// Directed bench for load_sequencer with a synchronous-read memory model.
// Checks data, error flag, latency, read addresses and handshake.
module tb_load_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_addr = '0;
  logic [2:0]  req_func3 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata = '0;

  logic [31:0] mem [0:16383];
  logic [15:0] rd_q [$];

  int n_chk = 0;
  int n_fail = 0;

  load_sequencer #(.W_SIZE(32), .ADDR_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_func3 (req_func3),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= mem[mem_addr[15:2]];
      rd_q.push_back(mem_addr);
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // a2 is the second read address; only checked when nrd == 2
  task automatic load(
    input string       tag,
    input logic [15:0] a,
    input logic [2:0]  f,
    input logic [31:0] exp_d,
    input logic        exp_e,
    input int          exp_lat,
    input int          nrd,
    input logic [15:0] a2,
    input int          hold
  );
    int   c;
    logic [31:0] d0;
    logic        e0;
    @(posedge clk);
    #1;
    rd_q.delete();
    req_valid = 1'b1;
    req_addr  = a;
    req_func3 = f;
    @(negedge clk);
    chk({tag, "_rdy"}, req_ready, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!rsp_valid && c < 8);
    chk({tag, "_lat"}, c, exp_lat);
    if (!rsp_valid) return;
    chk({tag, "_data"}, rsp_data, exp_d);
    chk({tag, "_err"}, rsp_err, exp_e);
    d0 = rsp_data;
    e0 = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_v"}, rsp_valid, 1'b1);
      chk({tag, "_hold_d"}, rsp_data, d0);
      chk({tag, "_hold_e"}, rsp_err, e0);
      chk({tag, "_hold_rdy"}, req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_done_v"}, rsp_valid, 1'b0);
    chk({tag, "_idle"}, req_ready, 1'b1);
    chk({tag, "_nrd"}, rd_q.size(), nrd);
    if (rd_q.size() > 0)
      chk({tag, "_a1"}, rd_q[0], {a[15:2], 2'b00});
    if (nrd == 2 && rd_q.size() > 1)
      chk({tag, "_a2"}, rd_q[1], a2);
  endtask

  initial begin
    bit seen;
    req_valid = 1'b1;
    req_addr  = 16'h0100;
    #1;
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_data", rsp_data, 32'h0);
    chk("rst_err", rsp_err, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_ready", req_ready, 1'b0);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", req_ready, 1'b1);
    chk("idle_mem_en", mem_en, 1'b0);

    mem[16'h0100 >> 2] = 32'hDEADBEEF;
    load("lw_al", 16'h0100, 3'd2, 32'hDEADBEEF, 1'b0, 2, 1, 16'h0, 0);

    mem[16'h0100 >> 2] = 32'h80011234;
    load("lh_2", 16'h0102, 3'd1, 32'hFFFF8001, 1'b0, 2, 1, 16'h0, 0);
    load("lhu_2", 16'h0102, 3'd5, 32'h00008001, 1'b0, 2, 1, 16'h0, 0);
    load("lb_3", 16'h0103, 3'd0, 32'hFFFFFF80, 1'b0, 2, 1, 16'h0, 0);
    load("lbu_3", 16'h0103, 3'd4, 32'h00000080, 1'b0, 2, 1, 16'h0, 0);
    load("ill3", 16'h0102, 3'd3, 32'h80011234, 1'b1, 2, 1, 16'h0, 0);
    load("ill6", 16'h0103, 3'd6, 32'h80011234, 1'b1, 2, 1, 16'h0, 0);

    mem[16'h0100 >> 2] = 32'hAABBCCDD;
    mem[16'h0104 >> 2] = 32'h11223344;
    load("lh_span", 16'h0103, 3'd1, 32'h000044AA, 1'b0, 3, 2, 16'h0104, 0);
    load("lhu_span", 16'h0103, 3'd5, 32'h000044AA, 1'b0, 3, 2, 16'h0104, 0);
    load("lw_span", 16'h0101, 3'd2, 32'h44AABBCC, 1'b0, 3, 2, 16'h0104, 0);
    load("lh_nospan", 16'h0102, 3'd1, 32'hFFFFAABB, 1'b0, 2, 1, 16'h0, 0);

    mem[16'hFFFC >> 2] = 32'h55667788;
    mem[0] = 32'h99AABBCC;
    load("lw_wrap", 16'hFFFE, 3'd2, 32'hBBCC5566, 1'b0, 3, 2, 16'h0000, 0);

    load("stall", 16'h0100, 3'd2, 32'hAABBCCDD, 1'b0, 2, 1, 16'h0, 3);

    // Abort a spanning load while it waits for its second word.
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = 16'h0101;
    req_func3 = 3'd2;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_mem_en", mem_en, 1'b0);
    chk("abort_valid", rsp_valid, 1'b0);
    chk("abort_ready", req_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("abort_no_rsp", seen, 1'b0);
    chk("abort_idle", req_ready, 1'b1);

    mem[0] = 32'h0000F000;
    load("lb_post", 16'h0001, 3'd0, 32'hFFFFFFF0, 1'b0, 2, 1, 16'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
